// File: rtl/params_pkg.sv
// params_pkg -- shared front-end parameters and types.
//   ADDR_WIDTH    : width of a program counter
//   INSTR_WIDTH   : width of an instruction word
//   instruction_t : raw instruction word
//   fdq_entry_t   : one fetch/decode queue entry {pc, instruction}; decode and
//                   debug logic reuse it to look at buffered instructions.
package params_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  typedef logic [INSTR_WIDTH-1:0] instruction_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    instruction_t          instruction;
  } fdq_entry_t;

endpackage : params_pkg

// File: rtl/fetch_decode_queue_storage.sv
// fdq_storage -- DEPTH-entry register array of fdq_entry_t.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : entry written on the rising edge when we=1
//   raddr : read index
//   rdata : entry at raddr (asynchronous read)
// Contents are deliberately not reset; the owner tracks which slots are live.
module fdq_storage #(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [PTR_W-1:0]         waddr,
  input  params_pkg::fdq_entry_t   wdata,
  input  logic [PTR_W-1:0]         raddr,
  output params_pkg::fdq_entry_t   rdata
);
  import params_pkg::*;

  fdq_entry_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Read is combinational so the head entry is visible the cycle after it is
  // written, giving the queue its 1-cycle fill latency.
  assign rdata = mem_reg[raddr];

endmodule : fdq_storage

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue -- elastic instruction buffer between fetch and decode.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   valid_i, pc_i,
//   instruction_i, ready_o   : fetch-side push handshake
//   flush_i                  : redirect; discards every buffered entry
//   valid_o, pc_o,
//   instruction_o, ready_i   : decode-side pop handshake (oldest entry)
//   count_o                  : current occupancy
// Optional macro FETCH_DECODE_QUEUE_BYPASS_EN: when the queue is empty and
// decode is ready, the fetch beat passes straight through with 0-cycle latency
// and is never stored. Without it the outputs are purely registered.
module fetch_decode_queue #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic [ADDR_WIDTH-1:0]    pc_i,
  input  params_pkg::instruction_t instruction_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [ADDR_WIDTH-1:0]    pc_o,
  output params_pkg::instruction_t instruction_o,
  input  logic                     ready_i,
  output logic [CNT_WIDTH-1:0]     count_o
);
  import params_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic [PTR_W-1:0]     rptr_reg, rptr_next;
  logic [PTR_W-1:0]     wptr_reg, wptr_next;

  logic       empty;
  logic       push, pop;
  logic       bypass_fire;
  logic       wr_en, rd_adv;
  fdq_entry_t wr_entry, head_entry;

  assign empty   = (count_reg == '0);
  assign ready_o = (count_reg != FULL_CNT);
  assign count_o = count_reg;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  // Empty queue: decode sees the fetch beat directly.
  assign bypass_fire   = empty & valid_i & ready_i & ~flush_i;
  assign valid_o       = ~empty | (valid_i & ~flush_i);
  assign pc_o          = empty ? pc_i : head_entry.pc;
  assign instruction_o = empty ? instruction_i : head_entry.instruction;
`else
  assign bypass_fire   = 1'b0;
  assign valid_o       = ~empty;
  assign pc_o          = head_entry.pc;
  assign instruction_o = head_entry.instruction;
`endif

  assign push = valid_i & ready_o & ~flush_i;
  assign pop  = valid_o & ready_i & ~flush_i;

  // A bypassed beat is both pushed and popped in the same cycle without ever
  // touching storage, so neither pointer nor count moves.
  assign wr_en  = push & ~bypass_fire;
  assign rd_adv = pop & ~bypass_fire;

  assign wr_entry.pc          = pc_i;
  assign wr_entry.instruction = instruction_i;

  fdq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk_i),
    .we    (wr_en),
    .waddr (wptr_reg),
    .wdata (wr_entry),
    .raddr (rptr_reg),
    .rdata (head_entry)
  );

  always_comb begin
    count_next = count_reg;
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    if (flush_i) begin
      // Redirect beats any push or pop presented in the same cycle.
      count_next = '0;
      rptr_next  = '0;
      wptr_next  = '0;
    end else begin
      if (wr_en)  wptr_next = wptr_reg + PTR_W'(1);
      if (rd_adv) rptr_next = rptr_reg + PTR_W'(1);
      unique case ({wr_en, rd_adv})
        2'b10:   count_next = count_reg + CNT_WIDTH'(1);
        2'b01:   count_next = count_reg - CNT_WIDTH'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
      rptr_reg  <= '0;
      wptr_reg  <= '0;
    end else begin
      count_reg <= count_next;
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_reg <= FULL_CNT)
    else $error("fetch_decode_queue: occupancy above DEPTH");

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rd_adv |-> !empty)
    else $error("fetch_decode_queue: pop from empty queue");
`endif

endmodule : fetch_decode_queue

// File: tb/tb_fetch_decode_queue.sv
// Testbench for fetch_decode_queue: directed scenarios followed by random
// traffic, checked by a scoreboard queue of expected entries.
module tb_fetch_decode_queue;
  import params_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  valid_i = 1'b0;
  logic [ADDR_WIDTH-1:0] pc_i = '0;
  instruction_t          instruction_i = '0;
  logic                  ready_o;
  logic                  flush_i = 1'b0;
  logic                  valid_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  instruction_t          instruction_o;
  logic                  ready_i = 1'b0;
  logic [CNT_W-1:0]      count_o;

  int n_vec = 0;
  int n_err = 0;

  fdq_entry_t exp_q[$];

  always #5 clk_i = ~clk_i;

  fetch_decode_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .pc_i          (pc_i),
    .instruction_i (instruction_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .instruction_o (instruction_o),
    .ready_i       (ready_i),
    .count_o       (count_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model + monitor: sample between edges, compare, then advance the
  // model by what the coming rising edge will do.
  always @(negedge clk_i) begin
    int  sz;
    bit  e_valid, e_ready, e_pop, e_bypass;
    sz = exp_q.size();
    if (!rst_ni) begin
      exp_q.delete();
      chk("rst_valid_o", 64'(valid_o), 64'(0));
      chk("rst_ready_o", 64'(ready_o), 64'(1));
      chk("rst_count_o", 64'(count_o), 64'(0));
    end else begin
      e_ready  = (sz != DEPTH);
      e_bypass = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      e_valid  = (sz != 0) || (valid_i && !flush_i);
      e_bypass = (sz == 0) && valid_i && ready_i && !flush_i;
`else
      e_valid  = (sz != 0);
`endif
      chk("valid_o", 64'(valid_o), 64'(e_valid));
      chk("ready_o", 64'(ready_o), 64'(e_ready));
      chk("count_o", 64'(count_o), 64'(sz));
      e_pop = e_valid && ready_i && !flush_i;
      if (e_pop) begin
        if (e_bypass) begin
          chk("bypass_pc", 64'(pc_o), 64'(pc_i));
          chk("bypass_instr", 64'(instruction_o), 64'(instruction_i));
        end else begin
          chk("pop_pc", 64'(pc_o), 64'(exp_q[0].pc));
          chk("pop_instr", 64'(instruction_o), 64'(exp_q[0].instruction));
          void'(exp_q.pop_front());
        end
      end
      if (flush_i) begin
        exp_q.delete();
      end else if (valid_i && e_ready && !e_bypass) begin
        exp_q.push_back('{pc: pc_i, instruction: instruction_i});
      end
    end
  end

  function automatic instruction_t instr_of(input logic [ADDR_WIDTH-1:0] pc);
    return instruction_t'(pc * 32'h9E37_79B1 + 32'h1234_5677);
  endfunction

  // Present one beat for exactly one clock, inputs changing 1 time unit after
  // the rising edge.
  task automatic drive(input bit v, input logic [ADDR_WIDTH-1:0] pc,
                       input bit rdy, input bit fl);
    valid_i       = v;
    pc_i          = pc;
    instruction_i = instr_of(pc);
    ready_i       = rdy;
    flush_i       = fl;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit held;
    // Reset held for three cycles.
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Push two with decode stalled, then drain.
    drive(1, 'h10, 0, 0);
    drive(1, 'h11, 0, 0);
    drive(0, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0);

    // Streaming with decode always ready; pointers wrap several times.
    for (int i = 0; i < 8; i++) drive(1, ADDR_WIDTH'('h20 + i), 1, 0);
    repeat (2) drive(0, 0, 1, 0);

    // Full: push rejected while a pop happens, held pc accepted next cycle.
    drive(1, 'h40, 0, 0);
    drive(1, 'h41, 0, 0);
    drive(1, 'h42, 1, 0);
    drive(1, 'h42, 1, 0);
    repeat (2) drive(0, 0, 1, 0);

    // Flush beats a simultaneous push and pop.
    drive(1, 'h50, 0, 0);
    drive(1, 'h51, 0, 0);
    drive(1, 'h30, 1, 1);
    repeat (2) drive(0, 0, 1, 0);

    // Asynchronous reset between edges with one entry buffered.
    drive(1, 'h60, 0, 0);
    valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid_o", 64'(valid_o), 64'(0));
    chk("async_rst_count_o", 64'(count_o), 64'(0));
    chk("async_rst_ready_o", 64'(ready_o), 64'(1));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Random traffic; a rejected fetch beat is held stable until accepted.
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin
        valid_i       = ($urandom_range(0, 9) < 7);
        pc_i          = ADDR_WIDTH'($urandom);
        instruction_i = instruction_t'($urandom);
      end
      ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 19) == 0);
      @(negedge clk_i);
      held = valid_i && !ready_o && !flush_i;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("final_count_o", 64'(count_o), 64'(exp_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_decode_queue
